// File: rtl/burst_main_memory.sv
// Word-addressed backing store serving whole-block read and write bursts
// over valid/ready request, write-data and read-data channels.
module burst_main_memory #(
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 2048,
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 32,
    parameter int ACCESS_LAT  = 4,
    parameter int WRAP_FIRST  = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              WDATA_VALID,
    output logic              WDATA_READY,
    input  logic [DATA_W-1:0] WDATA,
    output logic              RDATA_VALID,
    input  logic              RDATA_READY,
    output logic [DATA_W-1:0] RDATA,
    output logic [(BLOCK_WORDS > 1 ? $clog2(BLOCK_WORDS) : 1)-1:0] RDATA_BEAT,
    output logic              RDATA_LAST,
    output logic              WRESP_VALID
);

    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int LAT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    localparam logic [IDX_W-1:0] MASK    = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_END =
        LAT_W'((ACCESS_LAT > 0) ? ACCESS_LAT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        RD_BURST,
        WR_BURST,
        WR_RESP
    } state_t;

    state_t           state;
    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0] base_q;
    logic [IDX_W-1:0] start_q;
    logic [CNT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             is_write;

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] req_base;
    logic [IDX_W-1:0] req_start;
    logic [IDX_W-1:0] first_base;
    logic [IDX_W-1:0] first_start;
    logic [IDX_W-1:0] first_word;
    logic [IDX_W-1:0] rd_word;
    logic [IDX_W-1:0] wr_word;
    logic             mem_we;
    logic             unused_addr;

    function automatic logic [IDX_W-1:0] beat_word(
        input logic [IDX_W-1:0] b,
        input logic [IDX_W-1:0] s,
        input logic [CNT_W-1:0] k
    );
        return b | ((s + IDX_W'(k)) & MASK);
    endfunction

    function automatic logic [OFF_W-1:0] beat_off(
        input logic [IDX_W-1:0] s,
        input logic [CNT_W-1:0] k
    );
        return OFF_W'((s + IDX_W'(k)) & MASK);
    endfunction

    // Upper address bits fold away: the store wraps modulo its depth.
    assign unused_addr = ^REQ_ADDR;
    assign req_idx     = REQ_ADDR[IDX_W-1:0];
    assign req_base    = req_idx & ~MASK;
    assign req_start   = (WRAP_FIRST != 0) ? (req_idx & MASK) : '0;

    // With zero latency the first beat is fetched on the accept edge,
    // before base_q/start_q hold the new request.
    assign first_base  = (state == IDLE) ? req_base : base_q;
    assign first_start = (state == IDLE) ? req_start : start_q;
    assign first_word  = beat_word(first_base, first_start, '0);
    assign rd_word     = beat_word(base_q, start_q, cnt);
    assign wr_word     = beat_word(base_q, '0, cnt);
    assign mem_we      = RST_N && (state == WR_BURST) && WDATA_VALID;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_word] <= WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            REQ_READY   <= 1'b0;
            WDATA_READY <= 1'b0;
            RDATA_VALID <= 1'b0;
            RDATA       <= '0;
            RDATA_BEAT  <= '0;
            RDATA_LAST  <= 1'b0;
            WRESP_VALID <= 1'b0;
            base_q      <= '0;
            start_q     <= '0;
            cnt         <= '0;
            lat_cnt     <= '0;
            is_write    <= 1'b0;
        end else begin
            WRESP_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    REQ_READY <= 1'b1;
                    if (REQ_READY && REQ_VALID) begin
                        REQ_READY <= 1'b0;
                        is_write  <= REQ_WRITE;
                        base_q    <= req_base;
                        start_q   <= req_start;
                        cnt       <= '0;
                        lat_cnt   <= '0;
                        if (ACCESS_LAT == 0) begin
                            if (REQ_WRITE) begin
                                WDATA_READY <= 1'b1;
                                state       <= WR_BURST;
                            end else begin
                                RDATA       <= mem[first_word];
                                RDATA_BEAT  <= beat_off(first_start, '0);
                                RDATA_LAST  <= (BLOCK_WORDS == 1);
                                RDATA_VALID <= 1'b1;
                                cnt         <= CNT_W'(1);
                                state       <= RD_BURST;
                            end
                        end else begin
                            state <= LAT;
                        end
                    end
                end
                LAT: begin
                    if (lat_cnt == LAT_END) begin
                        if (is_write) begin
                            WDATA_READY <= 1'b1;
                            state       <= WR_BURST;
                        end else begin
                            RDATA       <= mem[first_word];
                            RDATA_BEAT  <= beat_off(first_start, '0);
                            RDATA_LAST  <= (BLOCK_WORDS == 1);
                            RDATA_VALID <= 1'b1;
                            cnt         <= CNT_W'(1);
                            state       <= RD_BURST;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (RDATA_READY) begin
                        if (RDATA_LAST) begin
                            RDATA_VALID <= 1'b0;
                            RDATA_LAST  <= 1'b0;
                            REQ_READY   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            RDATA      <= mem[rd_word];
                            RDATA_BEAT <= beat_off(start_q, cnt);
                            RDATA_LAST <= (cnt == LAST_K);
                            cnt        <= cnt + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (WDATA_VALID) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_K) begin
                            WDATA_READY <= 1'b0;
                            WRESP_VALID <= 1'b1;
                            state       <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_main_memory.sv
// Randomised bench for burst_main_memory: two instances (natural and
// critical-word-first read order) share stimulus and a flat memory model.
module tb_burst_main_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        rdata_ready;

    logic        rr0, wr0, rv0, rl0, wp0;
    logic [31:0] rd0;
    logic [2:0]  rb0;
    logic        rr1, wr1, rv1, rl1, wp1;
    logic [31:0] rd1;
    logic [2:0]  rb1;

    logic [31:0] model [2048];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_main_memory #(.WRAP_FIRST(0)) dut0 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(rr0),
        .REQ_WRITE(req_write), .REQ_ADDR(req_addr),
        .WDATA_VALID(wdata_valid), .WDATA_READY(wr0), .WDATA(wdata),
        .RDATA_VALID(rv0), .RDATA_READY(rdata_ready), .RDATA(rd0),
        .RDATA_BEAT(rb0), .RDATA_LAST(rl0), .WRESP_VALID(wp0)
    );

    burst_main_memory #(.WRAP_FIRST(1)) dut1 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(rr1),
        .REQ_WRITE(req_write), .REQ_ADDR(req_addr),
        .WDATA_VALID(wdata_valid), .WDATA_READY(wr1), .WDATA(wdata),
        .RDATA_VALID(rv1), .RDATA_READY(rdata_ready), .RDATA(rd1),
        .RDATA_BEAT(rb1), .RDATA_LAST(rl1), .WRESP_VALID(wp1)
    );

    task automatic issue_req(input logic [31:0] addr, input logic wr,
                             output bit ok);
        int n = 0;
        while (!(rr0 && rr1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_ready_timeout rr0=%0b rr1=%0b want 1", rr0, rr1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic do_write(input logic [31:0] addr, input int mode,
                            input int abort_at, input bit gaps);
        logic [31:0] d [8];
        int idx, base, k, guard, cyc, nresp;
        bit ok, hs, aborted;
        idx  = int'(addr & 32'h7FF);
        base = idx - idx % 8;
        for (int i = 0; i < 8; i++) begin
            if (mode == 0)      d[i] = 32'(base + i);
            else if (mode == 1) d[i] = 32'hA0 + 32'(i);
            else                d[i] = $urandom;
        end
        issue_req(addr, 1'b1, ok);
        if (!ok) return;
        // Junk write beats during the access latency must be ignored.
        cyc = 1;
        wdata_valid = 1'b1;
        wdata = 32'hDEAD_BEEF;
        while (!wr0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 5 || wr1 !== 1'b1) begin
            errors++;
            $display("FAIL wready_latency got cycle %0d wr1=%0b want 5", cyc, wr1);
        end
        k = 0;
        guard = 0;
        aborted = 0;
        while (k < 8 && guard < 300 && !aborted) begin
            if (abort_at >= 0 && k == abort_at + 1) begin
                aborted = 1;
            end else begin
                wdata = d[k];
                wdata_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                hs = wdata_valid && wr0;
                @(posedge clk);
                if (hs) begin
                    model[base + k] = d[k];
                    k++;
                end
                @(negedge clk);
                guard++;
            end
        end
        if (aborted) begin
            // Beat k is offered on the reset edge and must not land.
            rst_n = 1'b0;
            wdata_valid = 1'b1;
            wdata = d[k];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rr0, wr0, rv0, rl0, wp0, rb0, rd0} !== '0 ||
                {rr1, wr1, rv1, rl1, wp1, rb1, rd1} !== '0) begin
                errors++;
                $display("FAIL abort_outputs d0=%h d1=%h want 0",
                         {rr0, wr0, rv0, rl0, wp0, rb0, rd0},
                         {rr1, wr1, rv1, rl1, wp1, rb1, rd1});
            end
            wdata_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            nresp = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                nresp += int'(wp0) + int'(wp1);
            end
            checks++;
            if (nresp != 0 || !rr0 || !rr1) begin
                errors++;
                $display("FAIL abort_resp wresp=%0d rr=%0b%0b want 0 and 11",
                         nresp, rr0, rr1);
            end
            return;
        end
        wdata_valid = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL write_timeout beats=%0d want 8", k);
            return;
        end
        checks++;
        if (wp0 !== 1'b1 || wp1 !== 1'b1) begin
            errors++;
            $display("FAIL wresp_pulse got %0b%0b want 11", wp0, wp1);
        end
        @(negedge clk);
        checks++;
        if (wp0 !== 1'b0 || wp1 !== 1'b0 || rr0 !== 1'b1 || rr1 !== 1'b1) begin
            errors++;
            $display("FAIL wresp_end wresp=%0b%0b rr=%0b%0b want 00 11",
                     wp0, wp1, rr0, rr1);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input bit stall,
                           input bit poke);
        int idx, base, st, cyc, w0, w1;
        bit ok;
        logic [36:0] e0, e1;
        idx  = int'(addr & 32'h7FF);
        base = idx - idx % 8;
        st   = idx % 8;
        rdata_ready = !stall;
        issue_req(addr, 1'b0, ok);
        if (!ok) return;
        cyc = 1;
        while (!rv0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL rvalid_latency got cycle %0d want 5", cyc);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            w0 = base + k;
            w1 = base + (st + k) % 8;
            e0 = {1'b1, (k == 7), 3'(k), model[w0]};
            e1 = {1'b1, (k == 7), 3'((st + k) % 8), model[w1]};
            if (stall) begin
                rdata_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    req_valid = poke && (s == 1);
                    req_write = 1'b1;
                    checks++;
                    if ({rv0, rl0, rb0, rd0} !== e0 ||
                        {rv1, rl1, rb1, rd1} !== e1 || rr0 || rr1) begin
                        errors++;
                        $display("FAIL stall_hold k=%0d d0=%h d1=%h rr=%0b%0b want %h %h 00",
                                 k, {rv0, rl0, rb0, rd0}, {rv1, rl1, rb1, rd1},
                                 rr0, rr1, e0, e1);
                    end
                    @(negedge clk);
                end
                req_valid = 1'b0;
                rdata_ready = 1'b1;
            end
            checks++;
            if ({rv0, rl0, rb0, rd0} !== e0 || {rv1, rl1, rb1, rd1} !== e1) begin
                errors++;
                $display("FAIL read_beat addr=%h k=%0d d0=%h d1=%h want %h %h",
                         addr, k, {rv0, rl0, rb0, rd0}, {rv1, rl1, rb1, rd1},
                         e0, e1);
            end
            @(negedge clk);
        end
        rdata_ready = 1'b0;
        checks++;
        if (rv0 || rv1 || !rr0 || !rr1) begin
            errors++;
            $display("FAIL read_end rv=%0b%0b rr=%0b%0b want 00 11",
                     rv0, rv1, rr0, rr1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        wdata_valid = 1'b0;
        wdata = '0;
        rdata_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rr0, wr0, rv0, rl0, wp0, rb0, rd0} !== '0 ||
            {rr1, wr1, rv1, rl1, wp1, rb1, rd1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs d0=%h d1=%h want 0",
                     {rr0, wr0, rv0, rl0, wp0, rb0, rd0},
                     {rr1, wr1, rv1, rl1, wp1, rb1, rd1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rr0 !== 1'b1 || rr1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b%0b want 11", rr0, rr1);
        end
    endtask

    task automatic test_preload();
        do_write(32'h000, 0, -1, 1'b0);
        do_write(32'h010, 0, -1, 1'b0);
        do_write(32'h7F8, 0, -1, 1'b1);
        do_write(32'h080, 0, -1, 1'b0);
    endtask

    task automatic test_read_order();
        do_read(32'h13, 1'b0, 1'b0);
    endtask

    task automatic test_write_gaps();
        do_write(32'h40, 1, -1, 1'b1);
        do_read(32'h45, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_read(32'h13, 1'b1, 1'b1);
    endtask

    task automatic test_addr_wrap();
        do_read(32'h0000_0807, 1'b0, 1'b0);
        do_read(32'h7FF, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        do_write(32'h083, 2, 3, 1'b0);
        do_read(32'h085, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(32, 63) * 8 + $urandom_range(0, 7));
            do_write(a | ($urandom & 32'hFFFF_F800), 2, -1, 1'b1);
            a = (a & 32'h7F8) | 32'($urandom_range(0, 7));
            do_read(a | ($urandom & 32'hFFFF_F800), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        do_read(32'h10, 1'b0, 1'b0);
        do_read(32'h07, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_order();
        test_write_gaps();
        test_stall();
        test_addr_wrap();
        test_abort();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
